fc_state_tx: RTL and testbench



---
 rtl/fc_state_tx.sv | 177 +++++++++++++++++
 tb/tb_fc_state_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_state_tx.sv
// FC port transmit sequencer: drives primitive sequences for the current port state
// and passes upstream frame words through while the link is Active.
package fc;
    typedef enum logic [3:0] {
        AC  = 4'd0,
        LR1 = 4'd1,
        LR2 = 4'd2,
        LR3 = 4'd3,
        LF1 = 4'd4,
        LF2 = 4'd5,
        OL1 = 4'd6,
        OL2 = 4'd7,
        OL3 = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        PRIM_IDLE,
        PRIM_LR,
        PRIM_LRR,
        PRIM_OLS,
        PRIM_NOS,
        PRIM_NONE
    } prim_t;

    localparam logic [31:0] W_IDLE = 32'hBC95B5B5;
    localparam logic [31:0] W_LR   = 32'hBC49BF49;
    localparam logic [31:0] W_LRR  = 32'hBC35BF49;
    localparam logic [31:0] W_OLS  = 32'hBC358A55;
    localparam logic [31:0] W_NOS  = 32'hBC55BF45;
    localparam logic [3:0]  K_PRIM = 4'b1000;

    function automatic prim_t map_primitive(input logic [31:0] word);
        case (word)
            W_IDLE:  return PRIM_IDLE;
            W_LR:    return PRIM_LR;
            W_LRR:   return PRIM_LRR;
            W_OLS:   return PRIM_OLS;
            W_NOS:   return PRIM_NOS;
            default: return PRIM_NONE;
        endcase
    endfunction
endpackage

// Purpose: TX word sequencer for an FC port, following the receive tracker state.
// Latency: one cycle from inputs/FSM decision to data/datak/link_up.
// Backpressure: in_ready only while FOLLOW+AC with no forced transition this cycle.
module fc_state_tx #(
    parameter int LR_TIMEOUT     = 1000000,
    parameter int OLS_MIN_CYCLES = 1000,
    parameter int NOS_MIN_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  fc::state_t  rx_state,
    input  logic        loss_of_sync,
    input  logic        offline_req,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] data,
    output logic [3:0]  datak,
    output logic        link_up
);
    localparam int LR_W     = (LR_TIMEOUT > 0) ? $clog2(LR_TIMEOUT + 1) : 1;
    localparam int HOLD_MAX = (NOS_MIN_CYCLES > OLS_MIN_CYCLES) ? NOS_MIN_CYCLES : OLS_MIN_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [LR_W-1:0]   LR_LIMIT = LR_W'(LR_TIMEOUT);
    localparam logic [HOLD_W-1:0] NOS_MIN  = HOLD_W'(NOS_MIN_CYCLES);
    localparam logic [HOLD_W-1:0] OLS_MIN  = HOLD_W'(OLS_MIN_CYCLES);

    typedef enum logic [1:0] {
        FOLLOW,
        F_LF1,
        F_OL1
    } ctl_t;

    ctl_t              state;
    ctl_t              state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [LR_W-1:0]   lr_cnt;
    logic              rx_in_lr;
    logic [31:0]       word_nx;
    logic [3:0]        k_nx;

    assign rx_in_lr = (rx_state == fc::LR1) || (rx_state == fc::LR2) || (rx_state == fc::LR3);

    // Loss of sync overrides everything, including an offline request.
    always_comb begin
        state_nx = state;
        if (loss_of_sync) begin
            state_nx = F_LF1;
        end else begin
            case (state)
                FOLLOW: begin
                    if (offline_req)
                        state_nx = F_OL1;
                    else if ((LR_TIMEOUT != 0) && (lr_cnt >= LR_LIMIT))
                        state_nx = F_LF1;
                end
                F_LF1: begin
                    if ((hold_cnt >= NOS_MIN) &&
                        ((rx_state == fc::OL2) || (rx_state == fc::LF2)))
                        state_nx = FOLLOW;
                end
                F_OL1: begin
                    if (!offline_req && (hold_cnt >= OLS_MIN))
                        state_nx = FOLLOW;
                end
                default: state_nx = FOLLOW;
            endcase
        end
    end

    assign in_ready = !reset && (state == FOLLOW) && (rx_state == fc::AC) && (state_nx == FOLLOW);

    always_comb begin
        word_nx = fc::W_OLS;
        k_nx    = fc::K_PRIM;
        case (state_nx)
            F_LF1: word_nx = fc::W_NOS;
            F_OL1: word_nx = fc::W_OLS;
            default: begin
                case (rx_state)
                    fc::AC: begin
                        if (in_valid && in_ready) begin
                            word_nx = in_data;
                            k_nx    = in_datak;
                        end else begin
                            word_nx = fc::W_IDLE;
                        end
                    end
                    fc::LR1: word_nx = fc::W_LR;
                    fc::LR2: word_nx = fc::W_LRR;
                    fc::LR3: word_nx = fc::W_IDLE;
                    fc::LF1: word_nx = fc::W_NOS;
                    fc::LF2: word_nx = fc::W_OLS;
                    fc::OL1: word_nx = fc::W_OLS;
                    fc::OL2: word_nx = fc::W_LR;
                    fc::OL3: word_nx = fc::W_OLS;
                    default: word_nx = fc::W_OLS;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FOLLOW;
            hold_cnt <= '0;
            lr_cnt   <= '0;
            data     <= fc::W_OLS;
            datak    <= fc::K_PRIM;
            link_up  <= 1'b0;
        end else begin
            state <= state_nx;

            if (state_nx != state)
                hold_cnt <= '0;
            else if (hold_cnt != '1)
                hold_cnt <= hold_cnt + HOLD_W'(1);

            // Counts consecutive link-recovery cycles while following the receiver.
            if ((state == FOLLOW) && (state_nx == FOLLOW) && rx_in_lr) begin
                if (lr_cnt != '1)
                    lr_cnt <= lr_cnt + LR_W'(1);
            end else begin
                lr_cnt <= '0;
            end

            data    <= word_nx;
            datak   <= k_nx;
            link_up <= (state_nx == FOLLOW) && (rx_state == fc::AC);
        end
    end
endmodule

// File: tb/tb_fc_state_tx.sv
// Bench for fc_state_tx: directed scenarios plus randomized traffic against a
// behavioural model, on two instances (LR timeout enabled and disabled).
module tb_fc_state_tx;
    import fc::*;

    localparam int LRT  = 16;
    localparam int NOSM = 6;
    localparam int OLSM = 5;
    localparam int MF = 0, MLF = 1, MOL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    state_t      rx_state = OL1;
    logic        loss_of_sync = 1'b0;
    logic        offline_req = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_datak = '0;
    logic        in_valid = 1'b0;

    logic        rdy_a, rdy_b, link_a, link_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  k_a, k_b;

    int checks = 0;
    int passes = 0;

    fc_state_tx #(.LR_TIMEOUT(LRT), .OLS_MIN_CYCLES(OLSM), .NOS_MIN_CYCLES(NOSM)) dut_a (
        .clk(clk), .reset(reset), .rx_state(rx_state), .loss_of_sync(loss_of_sync),
        .offline_req(offline_req), .in_data(in_data), .in_datak(in_datak),
        .in_valid(in_valid), .in_ready(rdy_a), .data(data_a), .datak(k_a), .link_up(link_a));

    fc_state_tx #(.LR_TIMEOUT(0), .OLS_MIN_CYCLES(OLSM), .NOS_MIN_CYCLES(NOSM)) dut_b (
        .clk(clk), .reset(reset), .rx_state(rx_state), .loss_of_sync(loss_of_sync),
        .offline_req(offline_req), .in_data(in_data), .in_datak(in_datak),
        .in_valid(in_valid), .in_ready(rdy_b), .data(data_b), .datak(k_b), .link_up(link_b));

    always #5 clk = ~clk;

    // Behavioural model: mode, hold and LR-dwell counts as plain integers.
    int          m_mode[2] = '{MF, MF};
    int          m_hold[2] = '{0, 0};
    int          m_lr[2]   = '{0, 0};
    int          lrt[2]    = '{LRT, 0};
    logic [31:0] e_data[2] = '{W_OLS, W_OLS};
    logic [3:0]  e_k[2]    = '{K_PRIM, K_PRIM};
    logic        e_link[2] = '{1'b0, 1'b0};
    logic [31:0] tbl[16];

    function automatic int m_next(int i);
        if (loss_of_sync) return MLF;
        if (m_mode[i] == MF) begin
            if (offline_req) return MOL;
            if (lrt[i] != 0 && m_lr[i] >= lrt[i]) return MLF;
            return MF;
        end
        if (m_mode[i] == MLF)
            return (m_hold[i] >= NOSM && (rx_state == OL2 || rx_state == LF2)) ? MF : MLF;
        return (!offline_req && m_hold[i] >= OLSM) ? MF : MOL;
    endfunction

    function automatic logic m_rdy(int i);
        return !reset && m_mode[i] == MF && rx_state == AC && m_next(i) == MF;
    endfunction

    function automatic logic [31:0] m_word(int i);
        if (m_next(i) == MLF) return W_NOS;
        if (m_next(i) == MOL) return W_OLS;
        if (rx_state != AC) return tbl[rx_state];
        return (m_rdy(i) && in_valid) ? in_data : W_IDLE;
    endfunction

    function automatic logic [3:0] m_kflags(int i);
        return (m_next(i) == MF && rx_state == AC && m_rdy(i) && in_valid) ? in_datak : K_PRIM;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_mode[i] <= MF;
                m_hold[i] <= 0;
                m_lr[i]   <= 0;
                e_data[i] <= W_OLS;
                e_k[i]    <= K_PRIM;
                e_link[i] <= 1'b0;
            end else begin
                m_mode[i] <= m_next(i);
                m_hold[i] <= (m_next(i) != m_mode[i]) ? 0 : m_hold[i] + 1;
                m_lr[i]   <= (m_mode[i] == MF && m_next(i) == MF &&
                              rx_state inside {LR1, LR2, LR3}) ? m_lr[i] + 1 : 0;
                e_data[i] <= m_word(i);
                e_k[i]    <= m_kflags(i);
                e_link[i] <= (m_next(i) == MF) && (rx_state == AC);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_state = OL1;
        tick(); tick();
        checks++; if (data_a !== W_OLS) $display("FAIL rst_data actual=%h required=%h", data_a, W_OLS); else passes++;
        checks++; if (k_a !== 4'b1000) $display("FAIL rst_datak actual=%b required=1000", k_a); else passes++;
        checks++; if (link_a !== 1'b0 || link_b !== 1'b0) $display("FAIL rst_link actual=%b%b required=00", link_a, link_b); else passes++;
        checks++; if (rdy_a !== 1'b0) $display("FAIL rst_ready actual=%b required=0", rdy_a); else passes++;
        reset = 1'b0; rx_state = OL2;
        tick();
        checks++; if (map_primitive(data_a) !== PRIM_LR) $display("FAIL seq_ol2 actual=%h required=%h", data_a, W_LR); else passes++;
        rx_state = LR3;
        tick();
        checks++; if (data_a !== W_IDLE || link_a !== 1'b0) $display("FAIL seq_lr3 actual=%h/%b required=%h/0", data_a, link_a, W_IDLE); else passes++;
        rx_state = AC;
        tick();
        checks++; if (data_a !== W_IDLE || link_a !== 1'b1) $display("FAIL seq_ac actual=%h/%b required=%h/1", data_a, link_a, W_IDLE); else passes++;
    endtask

    task automatic test_frame_pass();
        rx_state = AC; in_valid = 1'b1; in_data = 32'h11223344; in_datak = 4'h0;
        #1;
        checks++; if (rdy_a !== 1'b1) $display("FAIL frame_ready actual=%b required=1", rdy_a); else passes++;
        tick();
        checks++; if (data_a !== 32'h11223344 || k_a !== 4'h0) $display("FAIL frame_word actual=%h/%b required=11223344/0000", data_a, k_a); else passes++;
        in_valid = 1'b0;
        tick();
        checks++; if (data_a !== W_IDLE || k_a !== K_PRIM) $display("FAIL frame_idle actual=%h/%b required=%h/1000", data_a, k_a, W_IDLE); else passes++;
    endtask

    task automatic test_loss_of_sync();
        rx_state = AC; loss_of_sync = 1'b1; in_valid = 1'b1;
        #1;
        checks++; if (rdy_a !== 1'b0) $display("FAIL los_ready actual=%b required=0", rdy_a); else passes++;
        tick();
        loss_of_sync = 1'b0;
        checks++; if (data_a !== W_NOS || link_a !== 1'b0) $display("FAIL los_nos actual=%h/%b required=%h/0", data_a, link_a, W_NOS); else passes++;
        for (int i = 0; i < NOSM + 2; i++) begin
            #1;
            checks++; if (rdy_a !== 1'b0) $display("FAIL los_hold_ready cyc=%0d actual=%b required=0", i, rdy_a); else passes++;
            tick();
            checks++; if (data_a !== W_NOS) $display("FAIL los_hold cyc=%0d actual=%h required=%h", i, data_a, W_NOS); else passes++;
        end
        in_valid = 1'b0; rx_state = OL2;
        tick();
        checks++; if (data_a !== W_LR) $display("FAIL los_exit actual=%h required=%h", data_a, W_LR); else passes++;
    endtask

    task automatic test_los_beats_offline();
        int n;
        rx_state = AC;
        tick();
        offline_req = 1'b1; loss_of_sync = 1'b1;
        tick();
        checks++; if (data_a !== W_NOS || data_b !== W_NOS) $display("FAIL prio_nos actual=%h/%h required=%h", data_a, data_b, W_NOS); else passes++;
        loss_of_sync = 1'b0;
        for (int i = 0; i < NOSM + 2; i++) begin
            tick();
            checks++; if (data_a !== W_NOS) $display("FAIL prio_stay cyc=%0d actual=%h required=%h", i, data_a, W_NOS); else passes++;
        end
        rx_state = OL2;
        tick();
        checks++; if (data_a !== W_LR) $display("FAIL prio_follow actual=%h required=%h", data_a, W_LR); else passes++;
        tick();
        checks++; if (data_a !== W_OLS) $display("FAIL prio_offline actual=%h required=%h", data_a, W_OLS); else passes++;
        offline_req = 1'b0; rx_state = AC;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_a !== W_OLS) break;
            n++;
        end
        checks++; if (n !== OLSM + 1 || data_a !== W_IDLE) $display("FAIL ols_min actual=%0d words then %h required=%0d then %h", n, data_a, OLSM + 1, W_IDLE); else passes++;
    endtask

    task automatic count_lrr_then_nos(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++; if (data_b !== W_LRR) $display("FAIL %s_no_timeout cyc=%0d actual=%h required=%h", tag, i, data_b, W_LRR); else passes++;
            if (data_a !== W_LRR) break;
            n++;
        end
        checks++; if (n !== LRT || data_a !== W_NOS) $display("FAIL %s_timeout actual=%0d LRR then %h required=%0d then %h", tag, n, data_a, LRT, W_NOS); else passes++;
    endtask

    task automatic recover_via_ol2();
        rx_state = OL2;
        for (int i = 0; i < NOSM + 2; i++) tick();
        checks++; if (data_a !== W_LR || data_b !== W_LR) $display("FAIL lr_recover actual=%h/%h required=%h", data_a, data_b, W_LR); else passes++;
    endtask

    task automatic test_lr_timeout();
        rx_state = AC;
        tick(); tick();
        rx_state = LR2;
        count_lrr_then_nos("lr");
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (data_b !== W_LRR || data_a !== W_NOS) $display("FAIL lr_dwell cyc=%0d actual=%h/%h required=%h/%h", i, data_a, data_b, W_NOS, W_LRR); else passes++;
        end
        recover_via_ol2();
    endtask

    task automatic test_reset_mid();
        rx_state = AC; in_valid = 1'b1; in_data = 32'hA5A50001; in_datak = 4'b0001;
        tick();
        checks++; if (data_a !== 32'hA5A50001) $display("FAIL mid_word actual=%h required=a5a50001", data_a); else passes++;
        in_data = 32'hA5A50002; reset = 1'b1;
        #1;
        checks++; if (rdy_a !== 1'b0) $display("FAIL mid_ready actual=%b required=0", rdy_a); else passes++;
        tick();
        checks++; if (data_a !== W_OLS || k_a !== K_PRIM || link_a !== 1'b0) $display("FAIL mid_reset actual=%h/%b/%b required=%h/1000/0", data_a, k_a, link_a, W_OLS); else passes++;
        reset = 1'b0; in_valid = 1'b0; rx_state = LR2;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_lrr_then_nos("rst_lr");
        recover_via_ol2();
    endtask

    task automatic test_random();
        logic [3:0] r;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            loss_of_sync = ($urandom_range(0, 59) == 0);
            if (!offline_req && $urandom_range(0, 79) == 0) offline_req = 1'b1;
            else if (offline_req && $urandom_range(0, 9) == 0) offline_req = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                r = 4'($urandom_range(0, 15));
                rx_state = state_t'(r);
            end else if ($urandom_range(0, 15) == 0) begin
                rx_state = AC;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            in_datak = 4'($urandom_range(0, 15));
            #1;
            checks++; if (rdy_a !== m_rdy(0) || rdy_b !== m_rdy(1)) $display("FAIL rnd_ready cyc=%0d actual=%b%b required=%b%b", c, rdy_a, rdy_b, m_rdy(0), m_rdy(1)); else passes++;
            tick();
            checks++; if (data_a !== e_data[0] || k_a !== e_k[0] || link_a !== e_link[0]) $display("FAIL rnd_a cyc=%0d actual=%h/%b/%b required=%h/%b/%b", c, data_a, k_a, link_a, e_data[0], e_k[0], e_link[0]); else passes++;
            checks++; if (data_b !== e_data[1] || k_b !== e_k[1] || link_b !== e_link[1]) $display("FAIL rnd_b cyc=%0d actual=%h/%b/%b required=%h/%b/%b", c, data_b, k_b, link_b, e_data[1], e_k[1], e_link[1]); else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = W_OLS;
        tbl[LR1] = W_LR;
        tbl[LR2] = W_LRR;
        tbl[LR3] = W_IDLE;
        tbl[LF1] = W_NOS;
        tbl[LF2] = W_OLS;
        tbl[OL1] = W_OLS;
        tbl[OL2] = W_LR;
        tbl[OL3] = W_OLS;
        test_reset();
        test_frame_pass();
        test_loss_of_sync();
        test_los_beats_offline();
        test_lr_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached after %0d/%0d checks", passes, checks);
        $fatal(1);
    end
endmodule
